// File: rtl/jt12_acc_sched.sv
// Operator slot sequencer for one YM2612 sample period (4 groups x 6 channels)
// plus the per-channel {rl,alg} table consumed by the accumulator.
module jt12_acc_sched #(
  parameter int         NCH    = 6,
  parameter logic [1:0] RL_RST = 2'b11
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clk_en_i,
  input  logic       sync_i,
  input  logic       cfg_we_i,
  input  logic [2:0] cfg_ch_i,
  input  logic [1:0] cfg_rl_i,
  input  logic [2:0] cfg_alg_i,
  input  logic [5:0] ch_mute_i,
  output logic [4:0] slot_o,
  output logic [2:0] cur_ch_o,
  output logic       zero_o,
  output logic       s1_enters_o,
  output logic       s2_enters_o,
  output logic       s3_enters_o,
  output logic       s4_enters_o,
  output logic       ch6op_o,
  output logic       channel_en_o,
  output logic [1:0] rl_o,
  output logic [2:0] alg_o,
  output logic       sample_rdy_o
);

  localparam logic [4:0] LAST = 5'(4*NCH - 1);
  localparam logic [4:0] C1   = 5'(NCH);
  localparam logic [4:0] C2   = 5'(2*NCH);
  localparam logic [4:0] C3   = 5'(3*NCH);

  typedef struct packed {
    logic [4:0] slot;
    logic [2:0] ch;
    logic       zero;
    logic       s1;
    logic       s2;
    logic       s3;
    logic       s4;
    logic       ch6op;
    logic       en;
    logic [1:0] rl;
    logic [2:0] alg;
    logic       rdy;
  } out_t;

  localparam out_t OUT_RST = '{slot: '0, ch: '0, zero: 1'b0, s1: 1'b0, s2: 1'b0,
                               s3: 1'b0, s4: 1'b0, ch6op: 1'b0, en: 1'b0,
                               rl: RL_RST, alg: '0, rdy: 1'b0};

  logic [4:0] cnt_q, cnt_d;
  logic [4:0] src;
  logic [4:0] ch5;
  logic [1:0] grp;
  logic [2:0] dch;
  out_t       out_q, out_d;
  logic [1:0] rl_tab_q  [NCH];
  logic [2:0] alg_tab_q [NCH];

  // sync decodes slot 0 in the same period, so the frame restarts without a gap
  always_comb begin
    src = sync_i ? 5'd0 : cnt_q;
    grp = 2'd3;
    ch5 = src - C3;
    if (src < C1) begin
      grp = 2'd0;
      ch5 = src;
    end else if (src < C2) begin
      grp = 2'd1;
      ch5 = src - C1;
    end else if (src < C3) begin
      grp = 2'd2;
      ch5 = src - C2;
    end
    dch = ch5[2:0];

    out_d       = out_q;
    out_d.slot  = src;
    out_d.ch    = dch;
    out_d.zero  = (src == 5'd0);
    out_d.rdy   = (src == 5'd0);
    // group order on the chip is S1, S3, S2, S4
    out_d.s1    = (grp == 2'd0);
    out_d.s3    = (grp == 2'd1);
    out_d.s2    = (grp == 2'd2);
    out_d.s4    = (grp == 2'd3);
    out_d.ch6op = (dch == 3'(NCH - 1));
    out_d.en    = ~ch_mute_i[dch];
    out_d.rl    = rl_tab_q[dch];
    out_d.alg   = alg_tab_q[dch];

    if (sync_i)             cnt_d = 5'd1;
    else if (cnt_q == LAST) cnt_d = 5'd0;
    else                    cnt_d = cnt_q + 5'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      out_q <= OUT_RST;
    end else if (clk_en_i) begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  // table writes are not gated by clk_en; readers see the pre-write value
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NCH; i++) begin
        rl_tab_q[i]  <= RL_RST;
        alg_tab_q[i] <= '0;
      end
    end else if (cfg_we_i && (cfg_ch_i < 3'(NCH))) begin
      rl_tab_q[cfg_ch_i]  <= cfg_rl_i;
      alg_tab_q[cfg_ch_i] <= cfg_alg_i;
    end
  end

  assign slot_o       = out_q.slot;
  assign cur_ch_o     = out_q.ch;
  assign zero_o       = out_q.zero;
  assign s1_enters_o  = out_q.s1;
  assign s2_enters_o  = out_q.s2;
  assign s3_enters_o  = out_q.s3;
  assign s4_enters_o  = out_q.s4;
  assign ch6op_o      = out_q.ch6op;
  assign channel_en_o = out_q.en;
  assign rl_o         = out_q.rl;
  assign alg_o        = out_q.alg;
  assign sample_rdy_o = out_q.rdy;

endmodule

// File: tb/tb_jt12_acc_sched.sv
// Bench for jt12_acc_sched: directed vector table, hand sequences for
// sync/reset, and random stimulus against a frame-level reference model.
module tb_jt12_acc_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b0, sync = 1'b0, cfg_we = 1'b0;
  logic [2:0] cfg_ch = '0;
  logic [1:0] cfg_rl = '0;
  logic [2:0] cfg_alg = '0;
  logic [5:0] ch_mute = '0;
  logic [4:0] slot;
  logic [2:0] cur_ch;
  logic       zero, s1, s2, s3, s4, ch6op, chen, rdy;
  logic [1:0] rl;
  logic [2:0] alg;

  int n_vec = 0;
  int n_err = 0;

  jt12_acc_sched dut (
    .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en), .sync_i(sync),
    .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_rl_i(cfg_rl), .cfg_alg_i(cfg_alg),
    .ch_mute_i(ch_mute), .slot_o(slot), .cur_ch_o(cur_ch), .zero_o(zero),
    .s1_enters_o(s1), .s2_enters_o(s2), .s3_enters_o(s3), .s4_enters_o(s4),
    .ch6op_o(ch6op), .channel_en_o(chen), .rl_o(rl), .alg_o(alg),
    .sample_rdy_o(rdy)
  );

  always #5 clk = ~clk;

  // reference model: frame position as an integer, table as plain arrays
  int       m_pos;
  bit [1:0] m_rl  [6];
  bit [2:0] m_alg [6];
  bit [19:0] e_vec;
  int        op_of_grp [4] = '{1, 3, 2, 4};

  function automatic bit [19:0] pack_exp(int s, int ch, bit z, int op, bit en,
                                         bit [1:0] r, bit [2:0] a, bit valid);
    bit [3:0] ops;
    ops = '0;
    if (valid) ops[op-1] = 1'b1;   // ops[0]=S1 .. ops[3]=S4
    return {5'(s), 3'(ch), z, ops[0], ops[1], ops[2], ops[3],
            valid && (ch == 5), en, r, a, z};
  endfunction

  function automatic bit [19:0] got_vec();
    return {slot, cur_ch, zero, s1, s2, s3, s4, ch6op, chen, rl, alg, rdy};
  endfunction

  task automatic model_clock();
    int s, g, c;
    if (rst) begin
      m_pos = 0;
      for (int i = 0; i < 6; i++) begin m_rl[i] = 2'b11; m_alg[i] = 3'd0; end
      e_vec = pack_exp(0, 0, 1'b0, 1, 1'b0, 2'b11, 3'd0, 1'b0);
    end else begin
      if (clk_en) begin
        s = sync ? 0 : m_pos;
        g = s / 6;
        c = s % 6;
        e_vec = pack_exp(s, c, s == 0, op_of_grp[g], !ch_mute[c], m_rl[c], m_alg[c], 1'b1);
        m_pos = (s + 1) % 24;
      end
      if (cfg_we && cfg_ch < 6) begin
        m_rl[cfg_ch]  = cfg_rl;
        m_alg[cfg_ch] = cfg_alg;
      end
    end
  endtask

  task automatic chk(string nm, bit [31:0] got, bit [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    chk("model", 32'(got_vec()), 32'(e_vec));
  endtask

  task automatic en_step();
    clk_en = 1'b1;
    step();
    clk_en = 1'b0;
  endtask

  typedef struct {
    bit       en, sy, we;
    bit [2:0] ch;
    bit [1:0] wrl;
    bit [2:0] walg;
    bit [5:0] mute;
    int       x_slot;
    bit       x_zero;
    bit [1:0] x_rl;
    bit [2:0] x_alg;
    bit       x_en;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int zc;
    //          en sy we ch wrl   walg mute       slot z rl    alg en
    tbl[0]  = '{1, 0, 0, 0, 2'b00, 0, 6'b000000,  0, 1, 2'b11, 0, 1};
    tbl[1]  = '{1, 0, 1, 2, 2'b10, 5, 6'b000000,  1, 0, 2'b11, 0, 1};
    tbl[2]  = '{1, 0, 1, 6, 2'b00, 7, 6'b000000,  2, 0, 2'b10, 5, 1};
    tbl[3]  = '{1, 0, 1, 3, 2'b01, 3, 6'b000000,  3, 0, 2'b11, 0, 1};
    tbl[4]  = '{0, 0, 0, 0, 2'b00, 0, 6'b000000,  3, 0, 2'b11, 0, 1};
    tbl[5]  = '{1, 0, 0, 0, 2'b00, 0, 6'b100001,  4, 0, 2'b11, 0, 1};
    tbl[6]  = '{1, 0, 0, 0, 2'b00, 0, 6'b100001,  5, 0, 2'b11, 0, 0};
    tbl[7]  = '{1, 0, 0, 0, 2'b00, 0, 6'b100001,  6, 0, 2'b11, 0, 0};
    tbl[8]  = '{1, 0, 0, 0, 2'b00, 0, 6'b100001,  7, 0, 2'b11, 0, 1};
    tbl[9]  = '{1, 0, 0, 0, 2'b00, 0, 6'b000000,  8, 0, 2'b10, 5, 1};
    tbl[10] = '{1, 0, 0, 0, 2'b00, 0, 6'b000000,  9, 0, 2'b01, 3, 1};
    tbl[11] = '{1, 0, 0, 0, 2'b00, 0, 6'b000000, 10, 0, 2'b11, 0, 1};

    // reset state
    rst = 1'b1; clk_en = 1'b1; sync = 1'b1;
    step(); step();
    chk("reset_outputs", 32'(got_vec()), 32'({5'd0, 3'd0, 7'd0, 1'b0, 2'b11, 3'd0, 1'b0}));
    rst = 1'b0; clk_en = 1'b0; sync = 1'b0;

    // directed table: config writes, write/read collision, mute
    foreach (tbl[i]) begin
      clk_en = tbl[i].en; sync = tbl[i].sy; cfg_we = tbl[i].we;
      cfg_ch = tbl[i].ch; cfg_rl = tbl[i].wrl; cfg_alg = tbl[i].walg;
      ch_mute = tbl[i].mute;
      step();
      chk($sformatf("table_row%0d", i), {slot, zero, rl, alg, chen},
          {5'(tbl[i].x_slot), tbl[i].x_zero, tbl[i].x_rl, tbl[i].x_alg, tbl[i].x_en});
    end
    clk_en = 1'b0; cfg_we = 1'b0; ch_mute = '0;

    // two full frames after reset
    rst = 1'b1; step(); rst = 1'b0;
    zc = 0;
    for (int i = 0; i < 48; i++) begin
      en_step();
      if (zero && rdy) zc++;
    end
    chk("zero_per_2frames", 32'(zc), 32'd2);

    // clk_en one clock in three
    for (int i = 0; i < 72; i++) begin
      clk_en = (i % 3 == 0);
      step();
    end
    clk_en = 1'b0;

    // sync mid-frame at output slot 13
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 14; i++) en_step();
    chk("pre_sync_slot", 32'(slot), 32'd13);
    sync = 1'b1; en_step(); sync = 1'b0;
    chk("sync_restart", {slot, zero, rdy, s1}, {5'd0, 1'b1, 1'b1, 1'b1});
    en_step();
    chk("sync_next", 32'(slot), 32'd1);

    // rst mid-frame at slot 17 restores the table
    cfg_we = 1'b1; cfg_ch = 3'd2; cfg_rl = 2'b01; cfg_alg = 3'd6;
    step(); cfg_we = 1'b0;
    for (int i = 0; i < 16; i++) en_step();
    chk("pre_rst_slot", 32'(slot), 32'd17);
    rst = 1'b1; clk_en = 1'b1; step(); rst = 1'b0; clk_en = 1'b0;
    chk("midframe_rst", 32'(got_vec()), 32'({5'd0, 3'd0, 7'd0, 1'b0, 2'b11, 3'd0, 1'b0}));
    for (int i = 0; i < 3; i++) en_step();
    chk("table_restored", {slot, rl, alg}, {5'd2, 2'b11, 3'd0});

    // random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      clk_en  = ($urandom_range(2) == 0);
      sync    = ($urandom_range(63) == 0);
      cfg_we  = ($urandom_range(5) == 0);
      cfg_ch  = 3'($urandom_range(7));
      cfg_rl  = 2'($urandom_range(3));
      cfg_alg = 3'($urandom_range(7));
      if ($urandom_range(15) == 0) ch_mute = 6'($urandom_range(63));
      rst     = ($urandom_range(599) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
